// File: rtl/mem_arb_pkg.sv
// Shared types and address-map constants for the memory port arbiters.
package mem_arb_pkg;

  typedef enum logic {
    REQ_DISP = 1'b0,
    REQ_BULK = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    oob;
  } tag_t;

  localparam int unsigned SIN_BASE       = 90000;
  localparam int unsigned RAM_BASE       = 90300;
  localparam int unsigned ADDR_LIMIT_DEF = 221371;

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth tag delay line that mirrors a registered memory read latency.
module mem_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe_d [READ_LATENCY];
  tag_t pipe_q [READ_LATENCY];

  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_out = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/mem_port_b_arbiter.sv
// Two-requester arbiter for read-only memory port B: fixed priority to the
// display fetch, with a starvation boost for the bulk reader.
module mem_port_b_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 24,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 8,
  parameter int ADDR_LIMIT   = ADDR_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic              oob_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt_d, wait_cnt_q;
  logic              boost;
  tag_t              tag_in, tag_out;
  logic              rvalid0_d, rvalid0_q, rvalid1_d, rvalid1_q;
  logic              oob_err_d, oob_err_q;
  logic [DATA_W-1:0] rdata0_d, rdata0_q, rdata1_d, rdata1_q;

  // Grants are gated by rst so nothing reaches the memory while held in reset.
  always_comb begin
    boost     = req1 && (wait_cnt_q == WAIT_MAX);
    gnt1      = !rst && req1 && (!req0 || boost);
    gnt0      = !rst && req0 && !gnt1;
    address_b = '0;
    if (gnt1) begin
      address_b = addr1;
    end else if (gnt0) begin
      address_b = addr0;
    end

    tag_in = '0;
    if (gnt0 || gnt1) begin
      tag_in.valid = 1'b1;
      tag_in.id    = gnt1 ? REQ_BULK : REQ_DISP;
      tag_in.oob   = (32'(address_b) > 32'(ADDR_LIMIT));
    end

    wait_cnt_d = wait_cnt_q;
    if (!req1 || gnt1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  mem_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Retire: the last tag stage lines up with read_data_b for the same read.
  always_comb begin
    rvalid0_d = tag_out.valid && (tag_out.id == REQ_DISP);
    rvalid1_d = tag_out.valid && (tag_out.id == REQ_BULK);
    oob_err_d = tag_out.valid && tag_out.oob;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (rvalid0_d) begin
      rdata0_d = tag_out.oob ? '0 : read_data_b;
    end
    if (rvalid1_d) begin
      rdata1_d = tag_out.oob ? '0 : read_data_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      oob_err_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      oob_err_q  <= oob_err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign oob_err = oob_err_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Directed bench for mem_port_b_arbiter with a latency-2 port-B memory model.
module tb_mem_port_b_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [17:0] addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, oob_err;
  logic [23:0] rdata0, rdata1, read_data_b;
  logic [17:0] address_b;
  logic [17:0] mem_addr_r = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [23:0] data;
    logic        oob;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mem_port_b_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .addr0      (addr0),
    .gnt0       (gnt0),
    .rvalid0    (rvalid0),
    .rdata0     (rdata0),
    .req1       (req1),
    .addr1      (addr1),
    .gnt1       (gnt1),
    .rvalid1    (rvalid1),
    .rdata1     (rdata1),
    .address_b  (address_b),
    .read_data_b(read_data_b),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] mem_f(input logic [17:0] a);
    if (a == 18'd100) return 24'hABCDEF;
    if (a >= 18'd90000 && a <= 18'd90299) return 24'h0;
    return 24'({6'b0, a} * 13 + 24'h123457);
  endfunction

  // Registered address then registered q: data two clocks after issue.
  always @(posedge clk) begin
    mem_addr_r  <= address_b;
    read_data_b <= mem_f(mem_addr_r);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit id, input logic [17:0] a);
    exp_t e;
    e.oob  = (a > 18'd221371);
    e.data = e.oob ? 24'h0 : mem_f(a);
    e.due  = cyc + 3;
    if (id) q1.push_back(e);
    else    q0.push_back(e);
  endtask

  // One arbitration cycle; called and returns at posedge+1.
  task automatic step(input logic r0, input logic [17:0] a0, input logic r1,
                      input logic [17:0] a1, input logic eg0, input logic eg1,
                      input string tag, input bit sb);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(negedge clk);
    chk({tag, " gnt0"}, gnt0, eg0);
    chk({tag, " gnt1"}, gnt1, eg1);
    chk({tag, " address_b"}, address_b, eg1 ? a1 : (eg0 ? a0 : 18'd0));
    if (sb && eg0) push(1'b0, a0);
    if (sb && eg1) push(1'b1, a1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt0"}, gnt0, 0);
    chk({tag, " gnt1"}, gnt1, 0);
    chk({tag, " address_b"}, address_b, 0);
    chk({tag, " rvalid0"}, rvalid0, 0);
    chk({tag, " rvalid1"}, rvalid1, 0);
    chk({tag, " rdata0"}, rdata0, 0);
    chk({tag, " rdata1"}, rdata1, 0);
    chk({tag, " oob_err"}, oob_err, 0);
  endtask

  // Response monitor: pops the scoreboard on each retire and checks timing.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_oob;
      exp_t e;
      exp_oob = 1'b0;
      if (rvalid0) begin
        if (q0.size() == 0) chk("rvalid0 spurious", rvalid0, 0);
        else begin
          e = q0.pop_front();
          chk("rdata0", rdata0, e.data);
          chk("rvalid0 cycle", cyc, e.due);
          exp_oob |= e.oob;
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        chk("rvalid0 missing", rvalid0, 1);
        void'(q0.pop_front());
      end
      if (rvalid1) begin
        if (q1.size() == 0) chk("rvalid1 spurious", rvalid1, 0);
        else begin
          e = q1.pop_front();
          chk("rdata1", rdata1, e.data);
          chk("rvalid1 cycle", cyc, e.due);
          exp_oob |= e.oob;
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        chk("rvalid1 missing", rvalid1, 1);
        void'(q1.pop_front());
      end
      chk("oob_err", oob_err, exp_oob);
    end
  end

  initial begin
    // Power-on reset with requests pending.
    req0 = 1'b1; req1 = 1'b1; addr0 = 18'd3; addr1 = 18'd4;
    @(negedge clk);
    chk_all_zero("por");
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b0;
    idle(2);

    // Single read from requester 0.
    step(1'b1, 18'd100, 1'b0, 18'd0, 1'b1, 1'b0, "single0", 1'b1);
    idle(5);

    // Reset one cycle after a grant: the in-flight read must vanish.
    step(1'b1, 18'd5, 1'b0, 18'd0, 1'b1, 1'b0, "rst_mid", 1'b0);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 18'd7; addr1 = 18'd9;
    @(negedge clk);
    chk_all_zero("rst_mid held");
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    idle(6);

    // Contention: requester 1 boosted on cycles 8, 17, 26.
    for (int i = 0; i < 30; i++) begin
      logic g1;
      g1 = (i == 8) || (i == 17) || (i == 26);
      step(1'b1, 18'(200 + i), 1'b1, 18'(1000 + i), !g1, g1, $sformatf("contend%0d", i), 1'b1);
    end
    idle(5);

    // Back-to-back routing across requesters.
    step(1'b1, 18'd10,    1'b0, 18'd0,     1'b1, 1'b0, "b2b_a", 1'b1);
    step(1'b0, 18'd0,     1'b1, 18'd95000, 1'b0, 1'b1, "b2b_b", 1'b1);
    step(1'b1, 18'd11,    1'b0, 18'd0,     1'b1, 1'b0, "b2b_c", 1'b1);
    idle(5);

    // Address limit boundary and sin window.
    step(1'b0, 18'd0, 1'b1, 18'd221372, 1'b0, 1'b1, "oob", 1'b1);
    idle(4);
    step(1'b0, 18'd0, 1'b1, 18'd221371, 1'b0, 1'b1, "limit", 1'b1);
    idle(4);
    step(1'b1, 18'd90150, 1'b0, 18'd0, 1'b1, 1'b0, "sin", 1'b1);
    idle(6);

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
